// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single write port of the general register bank.
// One registered grant per cycle, with optional per-requester lock bounded by LOCK_MAX.
module reg_write_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int LOCK_MAX     = 4,
    parameter int ZERO_DISCARD = 1
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [N_REQ-1:0]          REQ,
    input  logic [N_REQ-1:0]          REQ_LOCK,
    input  logic [N_REQ*ADDR_W-1:0]   REQ_ADDR,
    input  logic [N_REQ*DATA_W-1:0]   REQ_DATA,
    input  logic                      STALL,
    output logic [N_REQ-1:0]          GNT,
    output logic                      WE,
    output logic [ADDR_W-1:0]         WADDR,
    output logic [DATA_W-1:0]         WDATA,
    output logic                      BUSY
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]  ptr, ptr_next, win, idx;
    logic [3:0]        lcnt, lcnt_next;
    logic              found, grant, busy_next, we_next;
    logic [N_REQ-1:0]  gnt_next;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // Priority scan starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!found && REQ[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (PTR_W'(k) == win) begin
                win_addr = REQ_ADDR[k*ADDR_W +: ADDR_W];
                win_data = REQ_DATA[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        grant     = found && !STALL;
        gnt_next  = '0;
        ptr_next  = ptr;
        lcnt_next = '0;
        we_next   = 1'b0;
        busy_next = (|REQ) && (STALL || ($countones(REQ) > 1));
        if (grant) begin
            gnt_next[win] = 1'b1;
            we_next       = !((ZERO_DISCARD != 0) && (win_addr == '0));
            // A locked requester keeps the pointer until it has used LOCK_MAX grants.
            if (REQ_LOCK[win] && (lcnt < 4'(LOCK_MAX - 1))) begin
                ptr_next  = win;
                lcnt_next = lcnt + 4'd1;
            end else begin
                ptr_next  = (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);
                lcnt_next = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            GNT   <= '0;
            WE    <= 1'b0;
            WADDR <= '0;
            WDATA <= '0;
            BUSY  <= 1'b0;
            ptr   <= '0;
            lcnt  <= '0;
        end else begin
            GNT  <= gnt_next;
            WE   <= we_next;
            BUSY <= busy_next;
            ptr  <= ptr_next;
            lcnt <= lcnt_next;
            if (grant) begin
                WADDR <= win_addr;
                WDATA <= win_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter (N_REQ=4, LOCK_MAX=4, ZERO_DISCARD=1).
module tb_reg_write_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic                     CLK;
    logic                     RST_N;
    logic [N_REQ-1:0]         REQ;
    logic [N_REQ-1:0]         REQ_LOCK;
    logic [N_REQ*ADDR_W-1:0]  REQ_ADDR;
    logic [N_REQ*DATA_W-1:0]  REQ_DATA;
    logic                     STALL;
    logic [N_REQ-1:0]         GNT;
    logic                     WE;
    logic [ADDR_W-1:0]        WADDR;
    logic [DATA_W-1:0]        WDATA;
    logic                     BUSY;

    int checks = 0;
    int errors = 0;

    reg_write_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOCK_MAX(4), .ZERO_DISCARD(1)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .REQ_LOCK(REQ_LOCK),
        .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .STALL(STALL),
        .GNT(GNT), .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        REQ_ADDR[i*ADDR_W +: ADDR_W] = a;
        REQ_DATA[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        RST_N = 1'b0; REQ = '0; REQ_LOCK = '0; STALL = 1'b0;
        step();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        REQ_ADDR = '0; REQ_DATA = '0;
        for (int i = 0; i < N_REQ; i++) set_req(i, ADDR_W'(i + 1), 32'h1000_0000 + i);
        RST_N = 1'b0; REQ = 4'b1111; REQ_LOCK = '0; STALL = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (GNT !== 4'b0000 || WE !== 1'b0 || WADDR !== '0 || WDATA !== '0 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: GNT=%b WE=%b WADDR=%0d WDATA=%h BUSY=%b, expected all zero",
                         c, GNT, WE, WADDR, WDATA, BUSY);
            end
        end
        RST_N = 1'b1;
        step();
        checks++;
        if (GNT !== 4'b0001 || WADDR !== 5'd1 || WDATA !== 32'h1000_0000) begin
            errors++;
            $display("FAIL reset_first_grant: GNT=%b WADDR=%0d WDATA=%h, expected 0001 1 10000000", GNT, WADDR, WDATA);
        end
    endtask

    task automatic test_round_robin();
        logic [N_REQ-1:0]  exp_g [5];
        logic [ADDR_W-1:0] exp_a [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_a = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd1};
        do_reset();
        REQ = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (GNT !== exp_g[c] || WADDR !== exp_a[c] || WE !== 1'b1 || BUSY !== 1'b1) begin
                errors++;
                $display("FAIL round_robin step %0d: GNT=%b WADDR=%0d WE=%b BUSY=%b, expected %b %0d 1 1",
                         c, GNT, WADDR, WE, BUSY, exp_g[c], exp_a[c]);
            end
        end
        // Idle cycle: no grant, address/data hold the last write.
        REQ = '0;
        step();
        checks++;
        if (GNT !== 4'b0000 || WE !== 1'b0 || WADDR !== 5'd1 || WDATA !== 32'h1000_0000 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: GNT=%b WE=%b WADDR=%0d WDATA=%h BUSY=%b, expected 0000 0 1 10000000 0",
                     GNT, WE, WADDR, WDATA, BUSY);
        end
    endtask

    task automatic test_lock_limit();
        logic [N_REQ-1:0] exp_g [9];
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                  4'b0001, 4'b0001, 4'b0001, 4'b0001};
        do_reset();
        REQ = 4'b0011; REQ_LOCK = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            step();
            checks++;
            if (GNT !== exp_g[c]) begin
                errors++;
                $display("FAIL lock_limit step %0d: GNT=%b, expected %b", c, GNT, exp_g[c]);
            end
        end
        REQ = '0; REQ_LOCK = '0;
    endtask

    task automatic test_stall();
        do_reset();
        set_req(2, 5'd19, 32'hCAFE_0002);
        REQ = 4'b0100; STALL = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (GNT !== 4'b0000 || WE !== 1'b0 || BUSY !== 1'b1 || WADDR !== 5'd0) begin
                errors++;
                $display("FAIL stall cycle %0d: GNT=%b WE=%b BUSY=%b WADDR=%0d, expected 0000 0 1 0",
                         c, GNT, WE, BUSY, WADDR);
            end
        end
        STALL = 1'b0;
        step();
        checks++;
        if (GNT !== 4'b0100 || WE !== 1'b1 || WADDR !== 5'd19 || WDATA !== 32'hCAFE_0002 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: GNT=%b WE=%b WADDR=%0d WDATA=%h BUSY=%b, expected 0100 1 19 cafe0002 0",
                     GNT, WE, WADDR, WDATA, BUSY);
        end
        REQ = '0;
    endtask

    task automatic test_zero_discard();
        do_reset();
        set_req(1, 5'd0, 32'hDEAD_BEEF);
        REQ = 4'b0010;
        step();
        checks++;
        if (GNT !== 4'b0010 || WE !== 1'b0) begin
            errors++;
            $display("FAIL zero_discard: GNT=%b WE=%b, expected 0010 0", GNT, WE);
        end
        set_req(1, 5'd7, 32'hDEAD_BEEF);
        step();
        checks++;
        if (GNT !== 4'b0010 || WE !== 1'b1 || WADDR !== 5'd7 || WDATA !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL nonzero_write: GNT=%b WE=%b WADDR=%0d WDATA=%h, expected 0010 1 7 deadbeef",
                     GNT, WE, WADDR, WDATA);
        end
        REQ = '0;
    endtask

    task automatic test_reset_mid_burst();
        logic [N_REQ-1:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        do_reset();
        REQ = 4'b0011; REQ_LOCK = 4'b0001;
        step();
        checks++;
        if (GNT !== 4'b0001) begin
            errors++;
            $display("FAIL burst_first_grant: GNT=%b, expected 0001", GNT);
        end
        // Reset together with STALL at the second grant edge.
        RST_N = 1'b0; STALL = 1'b1;
        step();
        checks++;
        if (GNT !== 4'b0000 || WE !== 1'b0 || BUSY !== 1'b0 || WADDR !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid_burst: GNT=%b WE=%b BUSY=%b WADDR=%0d, expected 0000 0 0 0",
                     GNT, WE, BUSY, WADDR);
        end
        // Lock counter restarted: four grants to 0 before 1 gets its turn.
        RST_N = 1'b1; STALL = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (GNT !== exp_g[c]) begin
                errors++;
                $display("FAIL post_reset_burst step %0d: GNT=%b, expected %b", c, GNT, exp_g[c]);
            end
        end
        REQ = '0; REQ_LOCK = '0;
    endtask

    initial begin
        RST_N = 1'b0; REQ = '0; REQ_LOCK = '0; STALL = 1'b0;
        REQ_ADDR = '0; REQ_DATA = '0;
        #2;
        test_reset();
        test_round_robin();
        test_lock_limit();
        test_stall();
        test_zero_discard();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
